// File: rtl/calendar_pkg.sv
// calendar_pkg
//   Constants shared by the calendar counter chain and its set-mode controller:
//   field widths, field maxima (largest legal value of each field) and the
//   controller state encodings, which are also shown on the front-panel
//   mode display.
package calendar_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 5;
    localparam int MON_W  = 4;
    localparam int YEAR_W = 7;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int DAY_MAX  = 29;
    localparam int MON_MAX  = 11;
    localparam int YEAR_MAX = 99;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SET_YEAR  = 3'd1,
        ST_SET_MONTH = 3'd2,
        ST_SET_DAY   = 3'd3,
        ST_SET_HOUR  = 3'd4,
        ST_SET_MIN   = 3'd5,
        ST_COMMIT    = 3'd6
    } cal_state_e;

endpackage

// File: rtl/calendar_field_edit.sv
// calendar_field_edit
//   One editable calendar field: a wrapping up/down register that can be
//   loaded in parallel from a snapshot value.
//   Ports:
//     clk_i        system clock, rising edge
//     reset_i      asynchronous active-high reset, clears the field to 0
//     snap_i       load snap_val_i (takes priority over inc/dec)
//     snap_val_i   value captured from the live counter
//     inc_i/dec_i  step the field up/down; both together leave it unchanged
//     val_o        current field value
module calendar_field_edit
    import calendar_pkg::*;
#(
    parameter int W   = MIN_W,
    parameter int MAX = MIN_MAX
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         snap_i,
    input  logic [W-1:0] snap_val_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] val_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] val_q, val_d;

    // Snapshots are not range-checked, so an out-of-range value wraps to 0
    // on increment rather than climbing further.
    always_comb begin
        val_d = val_q;
        if (snap_i) begin
            val_d = snap_val_i;
        end else if (inc_i && !dec_i) begin
            val_d = (val_q >= MAX_V) ? '0 : val_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            val_d = (val_q == '0) ? MAX_V : val_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val_o = val_q;

endmodule

// File: rtl/calendar_set_ctrl.sv
// calendar_set_ctrl
//   Drives the calendar counter chain: generates the 1 Hz advance enable
//   (tick) from the system clock and runs the button-driven set-mode FSM
//   that snapshots the live calendar, lets the user edit year/month/day/
//   hour/minute and finally issues a one-cycle parallel load.
//   Ports:
//     clk, reset               system clock; asynchronous active-high reset
//     btn_mode/btn_inc/btn_dec debounced single-cycle button pulses
//     cur_*                    live counter values (snapshot source)
//     tick                     one-cycle calendar advance enable (RUN only)
//     load                     one-cycle parallel-load strobe
//     ld_*                     load values (ld_second is always 0)
//     mode                     current state encoding, busy = not RUN
//   Build option: define CALENDAR_SET_TIMEOUT_EN to abandon set mode after
//   TIMEOUT_TICKS calendar ticks without a button press.
module calendar_set_ctrl
    import calendar_pkg::*;
#(
    parameter int TICK_DIV      = 50000000,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [SEC_W-1:0]  cur_second,
    input  logic [MIN_W-1:0]  cur_minute,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [DAY_W-1:0]  cur_day,
    input  logic [MON_W-1:0]  cur_month,
    input  logic [YEAR_W-1:0] cur_year,
    output logic              tick,
    output logic              load,
    output logic [SEC_W-1:0]  ld_second,
    output logic [MIN_W-1:0]  ld_minute,
    output logic [HOUR_W-1:0] ld_hour,
    output logic [DAY_W-1:0]  ld_day,
    output logic [MON_W-1:0]  ld_month,
    output logic [YEAR_W-1:0] ld_year,
    output logic [2:0]        mode,
    output logic              busy
);

    localparam int              PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    if (TICK_DIV < 2 || TIMEOUT_TICKS < 1) begin : g_bad_params
        $error("calendar_set_ctrl: TICK_DIV must be >= 2 and TIMEOUT_TICKS >= 1");
    end

    cal_state_e       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_q, load_q, busy_q;
    logic             wrap, in_set, any_btn, timeout;
    logic             edit_inc, edit_dec, snap;

    assign wrap     = (pre_q == PRE_LAST);
    assign in_set   = (state_q >= ST_SET_YEAR) && (state_q <= ST_SET_MIN);
    assign any_btn  = btn_mode | btn_inc | btn_dec;
    // btn_mode wins over inc/dec; inc+dec together cancel inside the field.
    assign edit_inc = in_set && btn_inc && !btn_mode;
    assign edit_dec = in_set && btn_dec && !btn_mode;
    assign snap     = (state_q == ST_RUN) && btn_mode;

`ifdef CALENDAR_SET_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Counts calendar ticks (prescaler wraps) spent idle in a SET state.
    always_comb begin
        idle_d  = '0;
        timeout = 1'b0;
        if (in_set && !any_btn) begin
            idle_d = idle_q;
            if (wrap) begin
                if (idle_q == IDLE_W'(TIMEOUT_TICKS - 1)) begin
                    timeout = 1'b1;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:       if (btn_mode) state_d = ST_SET_YEAR;
            ST_SET_YEAR:  if (btn_mode) state_d = ST_SET_MONTH; else if (timeout) state_d = ST_RUN;
            ST_SET_MONTH: if (btn_mode) state_d = ST_SET_DAY;   else if (timeout) state_d = ST_RUN;
            ST_SET_DAY:   if (btn_mode) state_d = ST_SET_HOUR;  else if (timeout) state_d = ST_RUN;
            ST_SET_HOUR:  if (btn_mode) state_d = ST_SET_MIN;   else if (timeout) state_d = ST_RUN;
            ST_SET_MIN:   if (btn_mode) state_d = ST_COMMIT;    else if (timeout) state_d = ST_RUN;
            ST_COMMIT:    state_d = ST_RUN;
            default:      state_d = ST_RUN;
        endcase
    end

    // Clearing in COMMIT makes the first second after a load full length.
    assign pre_d = (state_q == ST_COMMIT || wrap) ? '0 : pre_q + 1'b1;

    // Outputs are computed from next-state values so they line up with the
    // registered state: tick coincides with the prescaler's last count in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tick_q  <= (state_d == ST_RUN) && (pre_d == PRE_LAST);
            load_q  <= (state_d == ST_COMMIT);
            busy_q  <= (state_d != ST_RUN);
        end
    end

    calendar_field_edit #(.W(YEAR_W), .MAX(YEAR_MAX)) u_year (
        .clk_i(clk), .reset_i(reset), .snap_i(snap), .snap_val_i(cur_year),
        .inc_i(edit_inc && state_q == ST_SET_YEAR),
        .dec_i(edit_dec && state_q == ST_SET_YEAR), .val_o(ld_year));

    calendar_field_edit #(.W(MON_W), .MAX(MON_MAX)) u_month (
        .clk_i(clk), .reset_i(reset), .snap_i(snap), .snap_val_i(cur_month),
        .inc_i(edit_inc && state_q == ST_SET_MONTH),
        .dec_i(edit_dec && state_q == ST_SET_MONTH), .val_o(ld_month));

    calendar_field_edit #(.W(DAY_W), .MAX(DAY_MAX)) u_day (
        .clk_i(clk), .reset_i(reset), .snap_i(snap), .snap_val_i(cur_day),
        .inc_i(edit_inc && state_q == ST_SET_DAY),
        .dec_i(edit_dec && state_q == ST_SET_DAY), .val_o(ld_day));

    calendar_field_edit #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .clk_i(clk), .reset_i(reset), .snap_i(snap), .snap_val_i(cur_hour),
        .inc_i(edit_inc && state_q == ST_SET_HOUR),
        .dec_i(edit_dec && state_q == ST_SET_HOUR), .val_o(ld_hour));

    calendar_field_edit #(.W(MIN_W), .MAX(MIN_MAX)) u_minute (
        .clk_i(clk), .reset_i(reset), .snap_i(snap), .snap_val_i(cur_minute),
        .inc_i(edit_inc && state_q == ST_SET_MIN),
        .dec_i(edit_dec && state_q == ST_SET_MIN), .val_o(ld_minute));

    // Seconds are not editable; a load always restarts the minute at :00.
    assign ld_second = '0;

    assign tick = tick_q;
    assign load = load_q;
    assign busy = busy_q;
    assign mode = state_q;

    // cur_second is part of the counter-chain interface but has no edit field.
    logic unused_ok;
    assign unused_ok = ^cur_second;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Testbench for calendar_set_ctrl (TICK_DIV=4, TIMEOUT_TICKS=3).
module tb_calendar_set_ctrl;

    localparam int TD = 4;
    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [5:0] cur_second = '0, cur_minute = '0;
    logic [4:0] cur_hour = '0, cur_day = '0;
    logic [3:0] cur_month = '0;
    logic [6:0] cur_year = '0;
    logic       tick, load, busy;
    logic [5:0] ld_second, ld_minute;
    logic [4:0] ld_hour, ld_day;
    logic [3:0] ld_month;
    logic [6:0] ld_year;
    logic [2:0] mode;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    calendar_set_ctrl #(.TICK_DIV(TD), .TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .reset(reset),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_second(cur_second), .cur_minute(cur_minute), .cur_hour(cur_hour),
        .cur_day(cur_day), .cur_month(cur_month), .cur_year(cur_year),
        .tick(tick), .load(load),
        .ld_second(ld_second), .ld_minute(ld_minute), .ld_hour(ld_hour),
        .ld_day(ld_day), .ld_month(ld_month), .ld_year(ld_year),
        .mode(mode), .busy(busy));

    // Reference model: a step index (0 = running, 1..5 = editing field
    // step-1, 6 = committing), the five field values and a cycle count
    // modulo TD.
    int m_s = 0, m_p = 0, m_i = 0;
    int m_f[5];                                   // year, month, day, hour, minute
    int fmax[5] = '{99, 11, 29, 23, 59};

    always @(posedge clk or posedge reset) begin : model
        int  old_s;
        bit  wrap;
`ifdef CALENDAR_SET_TIMEOUT_EN
        bit  anyb;
`endif
        if (reset) begin
            m_s = 0; m_p = 0; m_i = 0;
            for (int k = 0; k < 5; k++) m_f[k] = 0;
        end else begin
            old_s = m_s;
            wrap  = (m_p == TD - 1);
            if (old_s == 0) begin
                if (btn_mode) begin
                    m_f[0] = int'(cur_year);  m_f[1] = int'(cur_month);
                    m_f[2] = int'(cur_day);   m_f[3] = int'(cur_hour);
                    m_f[4] = int'(cur_minute);
                    m_s = 1;
                end
            end else if (old_s <= 5) begin
                if (btn_mode)
                    m_s = old_s + 1;
                else if (btn_inc && !btn_dec)
                    m_f[old_s-1] = (m_f[old_s-1] + 1) % (fmax[old_s-1] + 1);
                else if (btn_dec && !btn_inc)
                    m_f[old_s-1] = (m_f[old_s-1] + fmax[old_s-1]) % (fmax[old_s-1] + 1);
`ifdef CALENDAR_SET_TIMEOUT_EN
                anyb = btn_mode | btn_inc | btn_dec;
                if (anyb) m_i = 0;
                else if (wrap) begin
                    m_i = m_i + 1;
                    if (m_i == TO) begin m_s = 0; m_i = 0; end
                end
`endif
            end else begin
                m_s = 0;
            end
            m_p = (old_s == 6) ? 0 : (m_p + 1) % TD;
        end
    end

    function automatic logic [38:0] exp_vec();
        return {3'(m_s), (m_s != 0), (m_s == 6), (m_s == 0 && m_p == TD - 1),
                7'(m_f[0]), 4'(m_f[1]), 5'(m_f[2]), 5'(m_f[3]), 6'(m_f[4]), 6'd0};
    endfunction

    logic [38:0] act;
    assign act = {mode, busy, load, tick, ld_year, ld_month, ld_day, ld_hour, ld_minute, ld_second};

    // Drive one cycle of button pulses; returns 1 time unit after the edge.
    task automatic cyc(input logic m, input logic i, input logic d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        @(posedge clk); #1;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    endtask

    task automatic set_cur_random();
        cur_year   = 7'($urandom_range(0, 99));
        cur_month  = 4'($urandom_range(0, 11));
        cur_day    = 5'($urandom_range(0, 29));
        cur_hour   = 5'($urandom_range(0, 23));
        cur_minute = 6'($urandom_range(0, 59));
        cur_second = 6'($urandom_range(0, 59));
    endtask

    task automatic test_reset();
        int ticks = 0, loads = 0, last = -1;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (act !== 39'd0) begin
            n_errors++; $display("FAIL reset_values act=%h exp=%h", act, 39'd0);
        end
        reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (act !== exp_vec()) begin
                n_errors++; $display("FAIL reset_idle_model cyc=%0d act=%h exp=%h", c, act, exp_vec());
            end
            n_checks++;
            if (mode !== 3'd0) begin
                n_errors++; $display("FAIL reset_idle_mode cyc=%0d act=%0d exp=0", c, mode);
            end
            if (load === 1'b1) loads++;
            if (tick === 1'b1) begin
                ticks++;
                if (last >= 0) begin
                    n_checks++;
                    if (c - last != TD) begin
                        n_errors++; $display("FAIL tick_period act=%0d exp=%0d", c - last, TD);
                    end
                end
                last = c;
            end
        end
        n_checks++;
        if (ticks != 5) begin
            n_errors++; $display("FAIL tick_count act=%0d exp=5", ticks);
        end
        n_checks++;
        if (loads != 0) begin
            n_errors++; $display("FAIL idle_load_count act=%0d exp=0", loads);
        end
    endtask

    task automatic test_year_wrap();
        set_cur_random();
        cur_year = 7'd99;
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (mode !== 3'd1 || ld_year !== 7'd99) begin
            n_errors++; $display("FAIL year_snapshot mode=%0d year=%0d exp mode=1 year=99", mode, ld_year);
        end
        cyc(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (ld_year !== 7'd0) begin
            n_errors++; $display("FAIL year_wrap_inc act=%0d exp=0", ld_year);
        end
        cyc(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (ld_year !== 7'd1) begin
            n_errors++; $display("FAIL year_inc act=%0d exp=1", ld_year);
        end
        for (int k = 0; k < 6; k++) begin
            cyc(k < 5, 1'b0, 1'b0);
            n_checks++;
            if (act !== exp_vec()) begin
                n_errors++; $display("FAIL year_walk_model step=%0d act=%h exp=%h", k, act, exp_vec());
            end
        end
    endtask

    task automatic test_month_wrap();
        set_cur_random();
        cur_month = 4'd0;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (mode !== 3'd2 || ld_month !== 4'd0) begin
            n_errors++; $display("FAIL month_enter mode=%0d month=%0d exp mode=2 month=0", mode, ld_month);
        end
        cyc(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (ld_month !== 4'd11) begin
            n_errors++; $display("FAIL month_wrap_dec act=%0d exp=11", ld_month);
        end
        cyc(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (ld_month !== 4'd11) begin
            n_errors++; $display("FAIL month_inc_dec act=%0d exp=11", ld_month);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(k < 4, 1'b0, 1'b0);
            n_checks++;
            if (act !== exp_vec()) begin
                n_errors++; $display("FAIL month_walk_model step=%0d act=%h exp=%h", k, act, exp_vec());
            end
        end
    endtask

    task automatic test_full_pass();
        set_cur_random();
        cur_hour = 5'd23; cur_minute = 6'd5;
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (mode !== 3'd4) begin
            n_errors++; $display("FAIL pass_hour_state act=%0d exp=4", mode);
        end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (mode !== 3'd5 || load !== 1'b0) begin
            n_errors++; $display("FAIL pass_min_state mode=%0d load=%0b exp mode=5 load=0", mode, load);
        end
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if ({load, ld_second, ld_hour, ld_minute} !== {1'b1, 6'd0, 5'd0, 6'd4}) begin
            n_errors++;
            $display("FAIL pass_commit load=%0b sec=%0d hour=%0d min=%0d exp load=1 sec=0 hour=0 min=4",
                     load, ld_second, ld_hour, ld_minute);
        end
        n_checks++;
        if (act !== exp_vec()) begin
            n_errors++; $display("FAIL pass_commit_model act=%h exp=%h", act, exp_vec());
        end
        for (int n = 1; n <= TD; n++) begin
            cyc(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (tick !== (n == TD) || load !== 1'b0 || mode !== 3'd0) begin
                n_errors++;
                $display("FAIL pass_after_load n=%0d tick=%0b load=%0b mode=%0d exp tick=%0b load=0 mode=0",
                         n, tick, load, mode, (n == TD));
            end
        end
    endtask

    task automatic test_reset_midedit();
        int loads = 0;
        set_cur_random();
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (mode !== 3'd3 || busy !== 1'b1) begin
            n_errors++; $display("FAIL midedit_enter mode=%0d busy=%0b exp mode=3 busy=1", mode, busy);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (mode !== 3'd0 || busy !== 1'b0 || load !== 1'b0) begin
            n_errors++;
            $display("FAIL midedit_reset mode=%0d busy=%0b load=%0b exp 0/0/0", mode, busy, load);
        end
        @(posedge clk); #1 reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (load === 1'b1) loads++;
            n_checks++;
            if (act !== exp_vec()) begin
                n_errors++; $display("FAIL midedit_model cyc=%0d act=%h exp=%h", c, act, exp_vec());
            end
        end
        n_checks++;
        if (loads != 0) begin
            n_errors++; $display("FAIL midedit_load_count act=%0d exp=0", loads);
        end
    endtask

    task automatic test_timeout();
        int loads = 0;
        int guard = 0;
        logic [2:0] exp_mode;
`ifdef CALENDAR_SET_TIMEOUT_EN
        exp_mode = 3'd0;
`else
        exp_mode = 3'd1;
`endif
        set_cur_random();
        cyc(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 20 * TD; c++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (load === 1'b1) loads++;
            n_checks++;
            if (act !== exp_vec()) begin
                n_errors++; $display("FAIL timeout_model cyc=%0d act=%h exp=%h", c, act, exp_vec());
            end
        end
        n_checks++;
        if (mode !== exp_mode) begin
            n_errors++; $display("FAIL timeout_mode act=%0d exp=%0d", mode, exp_mode);
        end
        n_checks++;
        if (loads != 0) begin
            n_errors++; $display("FAIL timeout_load_count act=%0d exp=0", loads);
        end
        while (m_s != 0 && guard < 10) begin
            cyc(m_s != 6, 1'b0, 1'b0);
            guard++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) set_cur_random();
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            n_checks++;
            if (act !== exp_vec()) begin
                n_errors++; $display("FAIL random_model cyc=%0d act=%h exp=%h", c, act, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_year_wrap();
        test_month_wrap();
        test_full_pass();
        test_reset_midedit();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
